// File: rtl/chacha_aead_stream_sequencer_pkg.sv
// Shared widths, FSM encoding and byte-mask helpers for the AEAD stream sequencer.
package chacha_aead_stream_sequencer_pkg;

    localparam int BEAT_BYTES = 16;
    localparam int BEAT_W     = 8 * BEAT_BYTES;
    localparam int KS_BEATS   = 4;
    localparam int KS_W       = BEAT_W * KS_BEATS;
    localparam int KS_IDX_W   = $clog2(KS_BEATS);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AAD  = 3'd1,
        S_PLD  = 3'd2,
        S_LEN  = 3'd3,
        S_TAG  = 3'd4,
        S_DONE = 3'd5
    } seq_state_t;

    function automatic logic [4:0] popcount16(input logic [BEAT_BYTES-1:0] keep);
        logic [4:0] cnt;
        cnt = '0;
        for (int i = 0; i < BEAT_BYTES; i++) begin
            cnt = cnt + {4'd0, keep[i]};
        end
        return cnt;
    endfunction

    function automatic logic [BEAT_W-1:0] keep_mask(input logic [BEAT_BYTES-1:0] keep);
        logic [BEAT_W-1:0] m;
        m = '0;
        for (int i = 0; i < BEAT_BYTES; i++) begin
            m[8*i +: 8] = {8{keep[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/chacha_aead_stream_sequencer_ks_beat_buffer.sv
// Holds one 512-bit keystream block and hands it out as four 128-bit beats.
// Issues a registered one-cycle request when armed or when the last beat is used and more input follows.
module chacha_aead_stream_sequencer_ks_beat_buffer
    import chacha_aead_stream_sequencer_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_arm,
    input  logic              i_consume,
    input  logic              i_consume_last,
    input  logic              i_ks_valid,
    input  logic [KS_W-1:0]   i_ks_data,
    output logic              o_ks_req,
    output logic              o_full,
    output logic [BEAT_W-1:0] o_beat
);

    logic [KS_BEATS-1:0][BEAT_W-1:0] r_buf;
    logic [KS_IDX_W-1:0]             r_idx;
    logic                            r_full;
    logic                            r_pend;
    logic                            r_req;
    logic                            w_wrap;

    assign w_wrap = (r_idx == KS_IDX_W'(KS_BEATS - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_buf  <= '0;
            r_idx  <= '0;
            r_full <= 1'b0;
            r_pend <= 1'b0;
            r_req  <= 1'b0;
        end else begin
            r_req <= 1'b0;
            if (i_arm) begin
                // Any block left over from a previous op is discarded here.
                r_full <= 1'b0;
                r_idx  <= '0;
                r_req  <= 1'b1;
                r_pend <= 1'b1;
            end else begin
                if (i_consume) begin
                    if (w_wrap) begin
                        r_full <= 1'b0;
                        r_idx  <= '0;
                        if (!i_consume_last) begin
                            r_req  <= 1'b1;
                            r_pend <= 1'b1;
                        end
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                if (i_ks_valid && r_pend) begin
                    r_buf  <= i_ks_data;
                    r_full <= 1'b1;
                    r_idx  <= '0;
                    r_pend <= 1'b0;
                end
            end
        end
    end

    assign o_ks_req = r_req;
    assign o_full   = r_full;
    assign o_beat   = r_buf[r_idx];

endmodule

// File: rtl/chacha_aead_stream_sequencer.sv
// Host-side sequencer for a ChaCha20-Poly1305 core: AAD/payload split, keystream XOR,
// RFC 8439 length block and final tag assembly.
module chacha_aead_stream_sequencer
    import chacha_aead_stream_sequencer_pkg::*;
#(
    parameter bit TAG_ADD = 1'b1,
    parameter int CNT_W   = 64
)
(
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic                  i_dir_dec,
    input  logic                  i_has_aad,
    input  logic                  i_has_pld,
    output logic                  o_busy,
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    input  logic [BEAT_W-1:0]     i_in_data,
    input  logic [BEAT_BYTES-1:0] i_in_keep,
    input  logic                  i_in_last,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic [BEAT_W-1:0]     o_out_data,
    output logic [BEAT_BYTES-1:0] o_out_keep,
    output logic                  o_out_last,
    output logic                  o_aad_valid,
    output logic [BEAT_W-1:0]     o_aad_data,
    output logic [BEAT_BYTES-1:0] o_aad_keep,
    input  logic                  i_aad_ready,
    output logic                  o_pld_valid,
    output logic [BEAT_W-1:0]     o_pld_data,
    output logic [BEAT_BYTES-1:0] o_pld_keep,
    input  logic                  i_pld_ready,
    output logic                  o_len_valid,
    output logic [127:0]          o_len_block,
    input  logic                  i_len_ready,
    output logic                  o_ks_req,
    input  logic                  i_ks_valid,
    input  logic [KS_W-1:0]       i_ks_data,
    input  logic [127:0]          i_tag_pre_xor,
    input  logic                  i_tag_pre_xor_valid,
    input  logic [127:0]          i_tagmask,
    input  logic                  i_tagmask_valid,
    output logic [127:0]          o_tag,
    output logic                  o_tag_valid,
    input  logic                  i_tag_ready
);

    seq_state_t            r_state;
    logic                  r_dec;
    logic                  r_has_pld;
    logic [CNT_W-1:0]      r_aad_cnt;
    logic [CNT_W-1:0]      r_pld_cnt;
    logic                  r_pend_out;
    logic                  r_pend_pld;
    logic                  r_last_taken;
    logic [BEAT_W-1:0]     r_out_data;
    logic [BEAT_BYTES-1:0] r_out_keep;
    logic                  r_out_last;
    logic [BEAT_W-1:0]     r_pld_data;
    logic [BEAT_BYTES-1:0] r_pld_keep;
    logic                  r_len_valid;
    logic                  r_pre_ok;
    logic                  r_mask_ok;
    logic [127:0]          r_pre;
    logic [127:0]          r_mask;
    logic [127:0]          r_tag;
    logic                  r_tag_valid;

    logic                  w_in_aad;
    logic                  w_in_ready;
    logic                  w_aad_acc;
    logic                  w_pld_acc;
    logic                  w_ks_arm;
    logic                  w_ks_full;
    logic [BEAT_W-1:0]     w_ks_beat;
    logic [BEAT_W-1:0]     w_mask;
    logic [BEAT_W-1:0]     w_res;
    logic [127:0]          w_tag;
    logic                  w_collect;

    assign w_in_aad  = (r_state == S_AAD);
    assign w_aad_acc = w_in_aad & i_in_valid & i_aad_ready;
    assign w_pld_acc = (r_state == S_PLD) & i_in_valid & w_in_ready;
    assign w_ks_arm  = ((r_state == S_IDLE) & i_start & !i_has_aad & i_has_pld)
                     | (w_aad_acc & i_in_last & r_has_pld);
    assign w_mask    = keep_mask(i_in_keep);
    assign w_res     = (i_in_data ^ w_ks_beat) & w_mask;
    assign w_tag     = TAG_ADD ? (r_pre + r_mask) : (r_pre ^ r_mask);
    assign w_collect = (r_state != S_IDLE) && (r_state != S_DONE);

    // The last payload beat closes the section; no further beats until LEN.
    always_comb begin
        w_in_ready = 1'b0;
        case (r_state)
            S_AAD:   w_in_ready = i_aad_ready;
            S_PLD:   w_in_ready = w_ks_full & !r_pend_out & !r_pend_pld & !r_last_taken;
            default: w_in_ready = 1'b0;
        endcase
    end

    chacha_aead_stream_sequencer_ks_beat_buffer u_ks_buf (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_arm          (w_ks_arm),
        .i_consume      (w_pld_acc),
        .i_consume_last (i_in_last),
        .i_ks_valid     (i_ks_valid),
        .i_ks_data      (i_ks_data),
        .o_ks_req       (o_ks_req),
        .o_full         (w_ks_full),
        .o_beat         (w_ks_beat)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_dec        <= 1'b0;
            r_has_pld    <= 1'b0;
            r_aad_cnt    <= '0;
            r_pld_cnt    <= '0;
            r_pend_out   <= 1'b0;
            r_pend_pld   <= 1'b0;
            r_last_taken <= 1'b0;
            r_out_data   <= '0;
            r_out_keep   <= '0;
            r_out_last   <= 1'b0;
            r_pld_data   <= '0;
            r_pld_keep   <= '0;
            r_len_valid  <= 1'b0;
            r_pre_ok     <= 1'b0;
            r_mask_ok    <= 1'b0;
            r_pre        <= '0;
            r_mask       <= '0;
            r_tag        <= '0;
            r_tag_valid  <= 1'b0;
        end else begin
            // Tag halves may arrive in any order and at any point of the op.
            if (w_collect && i_tag_pre_xor_valid) begin
                r_pre    <= i_tag_pre_xor;
                r_pre_ok <= 1'b1;
            end
            if (w_collect && i_tagmask_valid) begin
                r_mask    <= i_tagmask;
                r_mask_ok <= 1'b1;
            end
            if (r_pend_out && i_out_ready) r_pend_out <= 1'b0;
            if (r_pend_pld && i_pld_ready) r_pend_pld <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_dec        <= i_dir_dec;
                        r_has_pld    <= i_has_pld;
                        r_aad_cnt    <= '0;
                        r_pld_cnt    <= '0;
                        r_pre_ok     <= 1'b0;
                        r_mask_ok    <= 1'b0;
                        r_last_taken <= 1'b0;
                        if (i_has_aad) begin
                            r_state <= S_AAD;
                        end else if (i_has_pld) begin
                            r_state <= S_PLD;
                        end else begin
                            r_state     <= S_LEN;
                            r_len_valid <= 1'b1;
                        end
                    end
                end
                S_AAD: begin
                    if (w_aad_acc) begin
                        r_aad_cnt <= r_aad_cnt + CNT_W'(popcount16(i_in_keep));
                        if (i_in_last) begin
                            if (r_has_pld) begin
                                r_state <= S_PLD;
                            end else begin
                                r_state     <= S_LEN;
                                r_len_valid <= 1'b1;
                            end
                        end
                    end
                end
                S_PLD: begin
                    if (w_pld_acc) begin
                        r_out_data   <= w_res;
                        r_out_keep   <= i_in_keep;
                        r_out_last   <= i_in_last;
                        r_pld_data   <= r_dec ? (i_in_data & w_mask) : w_res;
                        r_pld_keep   <= i_in_keep;
                        r_pend_out   <= 1'b1;
                        r_pend_pld   <= 1'b1;
                        r_pld_cnt    <= r_pld_cnt + CNT_W'(popcount16(i_in_keep));
                        r_last_taken <= i_in_last;
                    end else if (r_last_taken && !r_pend_out && !r_pend_pld) begin
                        r_state     <= S_LEN;
                        r_len_valid <= 1'b1;
                    end
                end
                S_LEN: begin
                    if (i_len_ready) begin
                        r_len_valid <= 1'b0;
                        r_state     <= S_TAG;
                    end
                end
                S_TAG: begin
                    if (r_pre_ok && r_mask_ok) begin
                        r_tag       <= w_tag;
                        r_tag_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (i_tag_ready) begin
                        r_tag_valid <= 1'b0;
                        r_tag       <= '0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_busy      = (r_state != S_IDLE);
    assign o_in_ready  = w_in_ready;
    assign o_aad_valid = w_in_aad & i_in_valid;
    assign o_aad_data  = w_in_aad ? i_in_data : '0;
    assign o_aad_keep  = w_in_aad ? i_in_keep : '0;
    assign o_out_valid = r_pend_out;
    assign o_out_data  = r_out_data;
    assign o_out_keep  = r_out_keep;
    assign o_out_last  = r_out_last;
    assign o_pld_valid = r_pend_pld;
    assign o_pld_data  = r_pld_data;
    assign o_pld_keep  = r_pld_keep;
    assign o_len_valid = r_len_valid;
    assign o_len_block = r_len_valid ? {64'(r_pld_cnt), 64'(r_aad_cnt)} : 128'd0;
    assign o_tag       = r_tag;
    assign o_tag_valid = r_tag_valid;

endmodule

// File: tb/tb_chacha_aead_stream_sequencer.sv
// Scoreboard bench for chacha_aead_stream_sequencer with a behavioural keystream responder.
module tb_chacha_aead_stream_sequencer;

    localparam bit TAG_ADD = 1'b1;

    logic         i_clk = 1'b0;
    logic         i_rst = 1'b1;
    logic         i_start = 1'b0, i_dir_dec = 1'b0, i_has_aad = 1'b0, i_has_pld = 1'b0;
    logic         o_busy;
    logic         i_in_valid = 1'b0, o_in_ready;
    logic [127:0] i_in_data = '0;
    logic [15:0]  i_in_keep = '0;
    logic         i_in_last = 1'b0;
    logic         o_out_valid, i_out_ready = 1'b1;
    logic [127:0] o_out_data;
    logic [15:0]  o_out_keep;
    logic         o_out_last;
    logic         o_aad_valid;
    logic [127:0] o_aad_data;
    logic [15:0]  o_aad_keep;
    logic         i_aad_ready = 1'b1;
    logic         o_pld_valid;
    logic [127:0] o_pld_data;
    logic [15:0]  o_pld_keep;
    logic         i_pld_ready = 1'b1;
    logic         o_len_valid;
    logic [127:0] o_len_block;
    logic         i_len_ready = 1'b0;
    logic         o_ks_req;
    logic         i_ks_valid = 1'b0;
    logic [511:0] i_ks_data = '0;
    logic [127:0] i_tag_pre_xor = '0;
    logic         i_tag_pre_xor_valid = 1'b0;
    logic [127:0] i_tagmask = '0;
    logic         i_tagmask_valid = 1'b0;
    logic [127:0] o_tag;
    logic         o_tag_valid;
    logic         i_tag_ready = 1'b0;

    chacha_aead_stream_sequencer #(.TAG_ADD(TAG_ADD), .CNT_W(64)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_dir_dec(i_dir_dec),
        .i_has_aad(i_has_aad), .i_has_pld(i_has_pld), .o_busy(o_busy),
        .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_in_data(i_in_data),
        .i_in_keep(i_in_keep), .i_in_last(i_in_last),
        .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_out_data(o_out_data),
        .o_out_keep(o_out_keep), .o_out_last(o_out_last),
        .o_aad_valid(o_aad_valid), .o_aad_data(o_aad_data), .o_aad_keep(o_aad_keep),
        .i_aad_ready(i_aad_ready),
        .o_pld_valid(o_pld_valid), .o_pld_data(o_pld_data), .o_pld_keep(o_pld_keep),
        .i_pld_ready(i_pld_ready),
        .o_len_valid(o_len_valid), .o_len_block(o_len_block), .i_len_ready(i_len_ready),
        .o_ks_req(o_ks_req), .i_ks_valid(i_ks_valid), .i_ks_data(i_ks_data),
        .i_tag_pre_xor(i_tag_pre_xor), .i_tag_pre_xor_valid(i_tag_pre_xor_valid),
        .i_tagmask(i_tagmask), .i_tagmask_valid(i_tagmask_valid),
        .o_tag(o_tag), .o_tag_valid(o_tag_valid), .i_tag_ready(i_tag_ready)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [127:0] d;
        logic [15:0]  k;
        logic         l;
    } beat_t;

    beat_t q_out[$], q_pld[$], q_aad[$];
    beat_t e_out, e_pld, e_aad;
    int    checks = 0, failures = 0;
    int    ks_reqs = 0, ks_blk = 0, aad_vld_cycles = 0, pld_beat_idx = 0;
    bit    stall_en = 1'b0, cur_dec = 1'b0;

    function automatic logic [511:0] ks_block(input int n);
        logic [511:0] b;
        for (int w = 0; w < 16; w++) begin
            b[32*w +: 32] = (32'h9E3779B9 * 32'(n * 16 + w + 1)) ^ 32'h5A5A0F0F;
        end
        return b;
    endfunction

    function automatic logic [15:0] keep_of(input int nb);
        logic [16:0] one_hot;
        one_hot = 17'd1 << nb;
        return (nb >= 16) ? 16'hFFFF : 16'(one_hot - 17'd1);
    endfunction

    function automatic logic [127:0] mask_of(input logic [15:0] k);
        logic [127:0] m;
        for (int i = 0; i < 16; i++) m[8*i +: 8] = {8{k[i]}};
        return m;
    endfunction

    // Keystream responder: one block two cycles after each request.
    always begin
        @(negedge i_clk);
        if (o_ks_req === 1'b1) begin
            ks_reqs++;
            @(posedge i_clk); #1;
            i_ks_valid = 1'b1;
            i_ks_data  = ks_block(ks_blk);
            ks_blk++;
            @(posedge i_clk); #1;
            i_ks_valid = 1'b0;
        end
    end

    always @(posedge i_clk) begin
        #1;
        if (stall_en) begin
            i_out_ready = 1'($urandom_range(0, 1));
            i_pld_ready = 1'($urandom_range(0, 1));
            i_aad_ready = 1'($urandom_range(0, 1));
        end else begin
            i_out_ready = 1'b1;
            i_pld_ready = 1'b1;
            i_aad_ready = 1'b1;
        end
    end

    always @(negedge i_clk) begin
        if (!i_rst) begin
            if (o_aad_valid) aad_vld_cycles++;
            if (o_aad_valid && i_aad_ready) begin
                checks++;
                if (q_aad.size() == 0) begin
                    failures++;
                    $display("FAIL aad_unexpected got=%h/%h", o_aad_data, o_aad_keep);
                end else begin
                    e_aad = q_aad.pop_front();
                    if ({o_aad_data, o_aad_keep} !== {e_aad.d, e_aad.k}) begin
                        failures++;
                        $display("FAIL aad_beat got=%h/%h exp=%h/%h", o_aad_data, o_aad_keep, e_aad.d, e_aad.k);
                    end
                end
            end
            if (o_out_valid && i_out_ready) begin
                checks++;
                if (q_out.size() == 0) begin
                    failures++;
                    $display("FAIL out_unexpected got=%h/%h", o_out_data, o_out_keep);
                end else begin
                    e_out = q_out.pop_front();
                    if ({o_out_data, o_out_keep, o_out_last} !== {e_out.d, e_out.k, e_out.l}) begin
                        failures++;
                        $display("FAIL out_beat got=%h/%h/%b exp=%h/%h/%b", o_out_data, o_out_keep,
                                 o_out_last, e_out.d, e_out.k, e_out.l);
                    end
                end
            end
            if (o_pld_valid && i_pld_ready) begin
                checks++;
                if (q_pld.size() == 0) begin
                    failures++;
                    $display("FAIL pld_unexpected got=%h/%h", o_pld_data, o_pld_keep);
                end else begin
                    e_pld = q_pld.pop_front();
                    if ({o_pld_data, o_pld_keep} !== {e_pld.d, e_pld.k}) begin
                        failures++;
                        $display("FAIL pld_beat got=%h/%h exp=%h/%h", o_pld_data, o_pld_keep, e_pld.d, e_pld.k);
                    end
                end
            end
        end
    end

    // All stimulus tasks start and end at posedge+1.
    task automatic do_start(input bit dec, input bit aad, input bit pld);
        ks_reqs = 0; ks_blk = 0; pld_beat_idx = 0; aad_vld_cycles = 0; cur_dec = dec;
        i_start = 1'b1; i_dir_dec = dec; i_has_aad = aad; i_has_pld = pld;
        @(posedge i_clk); #1;
        i_start = 1'b0;
    endtask

    task automatic send_beat(input bit is_pld, input logic [127:0] d, input logic [15:0] k, input bit last);
        beat_t        e;
        logic [511:0] kb;
        logic [127:0] m;
        bit           hs, rdy;
        m = mask_of(k);
        if (is_pld) begin
            kb  = ks_block(pld_beat_idx / 4);
            e.d = (d ^ kb[128*(pld_beat_idx % 4) +: 128]) & m;
            e.k = k; e.l = last;
            q_out.push_back(e);
            if (cur_dec) e.d = d & m;
            q_pld.push_back(e);
            pld_beat_idx++;
        end else begin
            e.d = d; e.k = k; e.l = last;
            q_aad.push_back(e);
        end
        i_in_valid = 1'b1; i_in_data = d; i_in_keep = k; i_in_last = last;
        hs = 1'b0;
        for (int c = 0; c < 300 && !hs; c++) begin
            @(negedge i_clk);
            rdy = o_in_ready;
            @(posedge i_clk); #1;
            hs = rdy;
        end
        i_in_valid = 1'b0; i_in_last = 1'b0;
        checks++;
        if (!hs) begin
            failures++;
            $display("FAIL in_accept got=timeout exp=accepted pld=%0b", is_pld);
        end
    endtask

    task automatic send_section(input bit is_pld, input int nbytes);
        int nb;
        nb = nbytes;
        while (nb > 0) begin
            send_beat(is_pld, {$urandom, $urandom, $urandom, $urandom}, keep_of(nb), nb <= 16);
            nb -= 16;
        end
    endtask

    task automatic wait_len(output logic [127:0] blk);
        bit got;
        got = 1'b0; blk = 'x;
        for (int c = 0; c < 400 && !got; c++) begin
            @(negedge i_clk);
            if (o_len_valid) begin
                got = 1'b1;
                blk = o_len_block;
            end
        end
        @(posedge i_clk); #1;
        i_len_ready = 1'b1;
        @(posedge i_clk); #1;
        i_len_ready = 1'b0;
    endtask

    task automatic tag_finish(input logic [127:0] pre, input logic [127:0] mask, input int gap,
                              input logic [127:0] exp);
        bit got;
        i_tagmask = mask; i_tagmask_valid = 1'b1;
        if (gap < 0) begin
            i_tag_pre_xor = pre; i_tag_pre_xor_valid = 1'b1;
        end
        @(posedge i_clk); #1;
        i_tagmask_valid = 1'b0; i_tag_pre_xor_valid = 1'b0;
        if (gap >= 0) begin
            repeat (gap - 1) begin @(posedge i_clk); #1; end
            i_tag_pre_xor = pre; i_tag_pre_xor_valid = 1'b1;
            @(posedge i_clk); #1;
            i_tag_pre_xor_valid = 1'b0;
        end
        got = 1'b0;
        for (int c = 0; c < 100 && !got; c++) begin
            @(negedge i_clk);
            got = o_tag_valid;
        end
        checks++;
        if (!got || o_tag !== exp) begin
            failures++;
            $display("FAIL tag_value got=%h valid=%b exp=%h", o_tag, got, exp);
        end
        @(posedge i_clk); #1;
        @(posedge i_clk); #1;
        @(negedge i_clk);
        checks++;
        if (o_tag_valid !== 1'b1 || o_tag !== exp) begin
            failures++;
            $display("FAIL tag_hold got=%h/%b exp=%h/1", o_tag, o_tag_valid, exp);
        end
        @(posedge i_clk); #1;
        i_tag_ready = 1'b1;
        @(posedge i_clk); #1;
        i_tag_ready = 1'b0;
        @(negedge i_clk);
        checks++;
        if (o_busy !== 1'b0 || o_tag_valid !== 1'b0) begin
            failures++;
            $display("FAIL tag_release busy=%b tag_valid=%b exp=0/0", o_busy, o_tag_valid);
        end
        @(posedge i_clk); #1;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        checks++;
        if ({o_busy, o_in_ready, o_out_valid, o_aad_valid, o_pld_valid, o_len_valid, o_ks_req, o_tag_valid} !== 8'd0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=00000000",
                     {o_busy, o_in_ready, o_out_valid, o_aad_valid, o_pld_valid, o_len_valid, o_ks_req, o_tag_valid});
        end
        checks++;
        if ({o_tag, o_len_block, o_out_data, o_pld_data} !== 512'd0) begin
            failures++;
            $display("FAIL reset_data tag=%h len=%h exp=0", o_tag, o_len_block);
        end
        i_rst = 1'b0;
        @(posedge i_clk); #1;
    endtask

    task automatic test_aad_pld();
        logic [127:0] blk, pre, mask;
        do_start(1'b0, 1'b1, 1'b1);
        send_section(1'b0, 12);
        send_section(1'b1, 34);
        wait_len(blk);
        checks++;
        if (blk !== {64'd34, 64'd12}) begin
            failures++;
            $display("FAIL aad_pld_len got=%h exp=%h", blk, {64'd34, 64'd12});
        end
        checks++;
        if (ks_reqs != 1) begin
            failures++;
            $display("FAIL aad_pld_ks_req got=%0d exp=1", ks_reqs);
        end
        pre  = {$urandom, $urandom, $urandom, $urandom};
        mask = {$urandom, $urandom, $urandom, $urandom};
        tag_finish(pre, mask, 1, pre + mask);
    endtask

    task automatic test_pld_only();
        logic [127:0] blk;
        do_start(1'b0, 1'b0, 1'b1);
        send_section(1'b1, 80);
        wait_len(blk);
        checks++;
        if (blk !== {64'd80, 64'd0}) begin
            failures++;
            $display("FAIL pld_only_len got=%h exp=%h", blk, {64'd80, 64'd0});
        end
        checks++;
        if (ks_reqs != 2) begin
            failures++;
            $display("FAIL pld_only_ks_req got=%0d exp=2", ks_reqs);
        end
        checks++;
        if (aad_vld_cycles != 0) begin
            failures++;
            $display("FAIL pld_only_aad_valid got=%0d exp=0", aad_vld_cycles);
        end
        tag_finish(128'h1111, 128'h2222, 2, 128'h3333);
    endtask

    task automatic test_empty_and_tag_order();
        logic [127:0] blk;
        do_start(1'b0, 1'b0, 1'b0);
        wait_len(blk);
        checks++;
        if (blk !== 128'd0) begin
            failures++;
            $display("FAIL empty_len got=%h exp=0", blk);
        end
        checks++;
        if (ks_reqs != 0) begin
            failures++;
            $display("FAIL empty_ks_req got=%0d exp=0", ks_reqs);
        end
        tag_finish({128{1'b1}}, 128'd1, 3, TAG_ADD ? 128'd0 : {{127{1'b1}}, 1'b0});
    endtask

    task automatic test_back_to_back_stalls();
        logic [127:0] blk;
        stall_en = 1'b1;
        do_start(1'b1, 1'b1, 1'b1);
        send_section(1'b0, 5);
        send_section(1'b1, 64);
        wait_len(blk);
        stall_en = 1'b0;
        checks++;
        if (blk !== {64'd64, 64'd5}) begin
            failures++;
            $display("FAIL stall_len got=%h exp=%h", blk, {64'd64, 64'd5});
        end
        checks++;
        if (q_out.size() + q_pld.size() + q_aad.size() != 0) begin
            failures++;
            $display("FAIL stall_drain got=%0d/%0d/%0d exp=0/0/0", q_out.size(), q_pld.size(), q_aad.size());
        end
        tag_finish(128'hABCD, 128'h0F0F, -1, 128'hABCD + 128'h0F0F);
    endtask

    task automatic test_reset_mid_pld();
        do_start(1'b0, 1'b0, 1'b1);
        send_beat(1'b1, {$urandom, $urandom, $urandom, $urandom}, 16'hFFFF, 1'b0);
        #1;
        i_rst = 1'b1;
        #1;
        checks++;
        if ({o_busy, o_in_ready, o_out_valid, o_pld_valid, o_ks_req, o_len_valid, o_tag_valid} !== 7'd0
            || o_out_data !== 128'd0) begin
            failures++;
            $display("FAIL reset_mid got=%b data=%h exp=0",
                     {o_busy, o_in_ready, o_out_valid, o_pld_valid, o_ks_req, o_len_valid, o_tag_valid}, o_out_data);
        end
        q_out.delete(); q_pld.delete(); q_aad.delete();
        repeat (3) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        test_aad_pld();
    endtask

    initial begin
        test_reset();
        test_aad_pld();
        test_pld_only();
        test_empty_and_tag_order();
        test_back_to_back_stalls();
        test_reset_mid_pld();
        checks++;
        if (q_out.size() + q_pld.size() + q_aad.size() != 0) begin
            failures++;
            $display("FAIL final_drain got=%0d exp=0", q_out.size() + q_pld.size() + q_aad.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
